clk_div_ctrl: RTL and testbench



---
 rtl/clk_div_ctrl_pkg.sv | 25 ++
 rtl/clk_div_ctrl_rr_arb2.sv | 17 +
 rtl/clk_div_ctrl.sv | 141 ++++++++++++++
 tb/tb_clk_div_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_ctrl_pkg.sv
// clk_div_ctrl_pkg: shared types and defaults for the CLK_div configuration
// sequencer.
//   state_t   - sequencer states
//   grantee_t - which requester owns the sequence in flight
package clk_div_ctrl_pkg;

   localparam int DIV_W       = 4;
   localparam int DEFAULT_DIV = 1;

   typedef enum logic [2:0] {
      INIT,
      IDLE,
      GATE,
      RST,
      SETTLE,
      ACK
   } state_t;

   typedef enum logic [1:0] {
      G_NONE,
      G_A,
      G_B
   } grantee_t;

endpackage

// File: rtl/clk_div_ctrl_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter, purely combinational.
//   en_i    - grant qualifier; no grant is issued while low
//   pri_i   - requester favoured on a tie (0: req_i[0], 1: req_i[1])
//   req_i   - request vector, bit 0 = A, bit 1 = B
//   gnt_o   - one-hot grant (all zero when idle or disabled)
module rr_arb2 (
   input  logic       en_i,
   input  logic       pri_i,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   // A lone requester always wins; on a tie pri_i breaks it.
   assign gnt_o[0] = en_i & req_i[0] & (~req_i[1] | ~pri_i);
   assign gnt_o[1] = en_i & req_i[1] & (~req_i[0] |  pri_i);

endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: arbitrates two requesters for the CLK_div ratio input and
// sequences every change glitch-free: gate CLK_EN, pulse the divider reset,
// load the new ratio, re-enable, settle, then acknowledge.
//   CLK, Reset      - reference clock, synchronous active-low reset
//   req_a/div_a     - requester A level request and ratio (sampled at grant)
//   req_b/div_b     - requester B level request and ratio (sampled at grant)
//   ack_a/ack_b     - one-cycle completion pulses
//   busy            - high whenever the sequencer is not in IDLE
//   CLK_EN          - divider enable
//   Div_Rst_n       - divider reset, active low
//   div             - ratio applied to the divider
// Every output is a register or a decode of the state register.
module clk_div_ctrl
   import clk_div_ctrl_pkg::*;
#(
   parameter int DIV_W         = clk_div_ctrl_pkg::DIV_W,
   parameter int DEFAULT_DIV   = clk_div_ctrl_pkg::DEFAULT_DIV,
   parameter int GATE_CYCLES   = 2,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             req_a,
   input  logic [DIV_W-1:0] div_a,
   input  logic             req_b,
   input  logic [DIV_W-1:0] div_b,
   output logic             ack_a,
   output logic             ack_b,
   output logic             busy,
   output logic             CLK_EN,
   output logic             Div_Rst_n,
   output logic [DIV_W-1:0] div
);

   localparam logic [3:0]       GATE_LAST   = 4'(GATE_CYCLES - 1);
   localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
   localparam logic [DIV_W-1:0] DIV_RST     = DIV_W'(DEFAULT_DIV);

   state_t           state_q, state_d;
   grantee_t         gnt_q, gnt_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] new_div_q, new_div_d;
   logic             pri_q, pri_d;      // 0: A wins a tie, 1: B wins a tie

   logic             arb_en;
   logic [1:0]       arb_gnt;
   logic [DIV_W-1:0] req_div;

   assign arb_en = (state_q == IDLE);

   rr_arb2 u_arb (
      .en_i  (arb_en),
      .pri_i (pri_q),
      .req_i ({req_b, req_a}),
      .gnt_o (arb_gnt)
   );

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      cnt_d     = cnt_q;
      div_d     = div_q;
      new_div_d = new_div_q;
      pri_d     = pri_q;
      req_div   = arb_gnt[1] ? div_b : div_a;

      case (state_q)
         INIT: begin
            cnt_d   = '0;
            gnt_d   = G_NONE;
            state_d = SETTLE;
         end
         IDLE: begin
            if (|arb_gnt) begin
               new_div_d = req_div;
               gnt_d     = arb_gnt[0] ? G_A : G_B;
               cnt_d     = '0;
               // Same ratio already applied: skip the gate/reset dance.
               state_d   = (req_div == div_q) ? ACK : GATE;
            end
         end
         GATE: begin
            if (cnt_q == GATE_LAST) begin
               cnt_d   = '0;
               state_d = RST;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         RST: begin
            div_d   = new_div_q;
            cnt_d   = '0;
            state_d = SETTLE;
         end
         SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               cnt_d   = '0;
               // The post-reset settle has nobody to acknowledge.
               state_d = (gnt_q == G_NONE) ? IDLE : ACK;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ACK: begin
            pri_d   = (gnt_q == G_A);
            gnt_d   = G_NONE;
            state_d = IDLE;
         end
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!Reset) begin
         state_q   <= INIT;
         gnt_q     <= G_NONE;
         cnt_q     <= '0;
         div_q     <= DIV_RST;
         new_div_q <= DIV_RST;
         pri_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         new_div_q <= new_div_d;
         pri_q     <= pri_d;
      end
   end

   // CLK_EN low only in INIT/GATE/RST; Div_Rst_n low only in INIT/RST, so
   // the divider is never enabled while held in reset.
   assign CLK_EN    = (state_q == IDLE) || (state_q == SETTLE) || (state_q == ACK);
   assign Div_Rst_n = (state_q != INIT) && (state_q != RST);
   assign busy      = (state_q != IDLE);
   assign ack_a     = (state_q == ACK) && (gnt_q == G_A);
   assign ack_b     = (state_q == ACK) && (gnt_q == G_B);
   assign div       = div_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed transaction table, a few
// hand-written corner sequences, and a randomized phase, all watched by a
// timeline model that predicts every output from the gate/reset/settle
// durations and the round-robin rule.
module tb_clk_div_ctrl;

   localparam int G   = 2;
   localparam int S   = 4;
   localparam int W   = 4;
   localparam int DEF = 1;
   localparam int FULL_LAT = G + 1 + S + 1;   // edges from sampling edge through ACK

   logic         CLK = 1'b0;
   logic         Reset = 1'b0;
   logic         req_a = 1'b0, req_b = 1'b0;
   logic [W-1:0] div_a = '0, div_b = '0;
   logic         ack_a, ack_b, busy, CLK_EN, Div_Rst_n;
   logic [W-1:0] div;

   int errors = 0;
   int checks = 0;
   int na = 0, nb = 0;   // ack pulse counts

   always #5 CLK = ~CLK;

   clk_div_ctrl #(.DIV_W(W), .DEFAULT_DIV(DEF), .GATE_CYCLES(G), .SETTLE_CYCLES(S)) dut (
      .CLK(CLK), .Reset(Reset),
      .req_a(req_a), .div_a(div_a), .req_b(req_b), .div_b(div_b),
      .ack_a(ack_a), .ack_b(ack_b), .busy(busy),
      .CLK_EN(CLK_EN), .Div_Rst_n(Div_Rst_n), .div(div)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- timeline model ----------------
   typedef enum {K_NONE, K_INIT, K_BOOT, K_IDLE, K_TXN} kind_t;
   kind_t k = K_NONE;
   int    n = 0, b = 0, m_len = 0, m_who = 0, m_new = 0, m_div = DEF;
   bit    m_fast = 0, m_pri = 0;   // m_pri 0: A wins a tie

   always @(negedge CLK) begin : mon
      int d, e_en, e_rst, e_busy, e_aa, e_ab;
      n++;
      d = n - b;
      if (ack_a) na++;
      if (ack_b) nb++;
      if (k != K_NONE) begin
         e_en = 1; e_rst = 1; e_busy = 1; e_aa = 0; e_ab = 0;
         case (k)
            K_INIT: begin e_en = 0; e_rst = 0; end
            K_IDLE: e_busy = 0;
            K_TXN: begin
               if (!m_fast) begin
                  if (d <= G) e_en = 0;
                  else if (d == G + 1) begin e_en = 0; e_rst = 0; end
                  else if (d == G + 2) m_div = m_new;
               end
               if (d == m_len) begin e_aa = (m_who == 1); e_ab = (m_who == 2); end
            end
            default: ;
         endcase
         chk("CLK_EN", CLK_EN, e_en);
         chk("Div_Rst_n", Div_Rst_n, e_rst);
         chk("busy", busy, e_busy);
         chk("ack_a", ack_a, e_aa);
         chk("ack_b", ack_b, e_ab);
         chk("div", div, m_div);
      end
      // advance using the inputs the next edge will sample
      if (!Reset) begin
         k = K_INIT; m_div = DEF; m_pri = 0;
      end else begin
         case (k)
            K_INIT: begin k = K_BOOT; b = n; end
            K_BOOT: if (d == S) k = K_IDLE;
            K_IDLE: if (req_a || req_b) begin
               m_who  = (req_a && (!req_b || !m_pri)) ? 1 : 2;
               m_new  = (m_who == 1) ? int'(div_a) : int'(div_b);
               m_fast = (m_new == m_div);
               m_len  = m_fast ? 1 : FULL_LAT;
               b = n; k = K_TXN;
            end
            K_TXN: if (d == m_len) begin k = K_IDLE; m_pri = (m_who == 1); end
            default: ;
         endcase
      end
   end

   // ---------------- helpers ----------------
   task automatic step();
      @(posedge CLK); #1;
   endtask

   task automatic wait_idle();
      int t;
      for (t = 0; t < 100 && busy !== 1'b0; t++) step();
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL wait_idle: busy still %0b after 100 cycles", busy);
      end
   endtask

   // steps until an ack; returns edge count (0 on timeout) and who (1 A, 2 B)
   task automatic wait_ack(input int budget, output int lat, output int who);
      lat = 0; who = 0;
      for (int t = 1; t <= budget; t++) begin
         step();
         if (ack_a || ack_b) begin lat = t; who = ack_a ? 1 : 2; break; end
      end
      if (who == 0) begin
         errors++;
         $display("FAIL wait_ack: no ack within %0d cycles", budget);
      end
   endtask

   task automatic drop(input int who);
      if (who == 1) req_a = 1'b0;
      if (who == 2) req_b = 1'b0;
   endtask

   typedef struct {
      bit ra; int da; bit rb; int db;
      int who1; int div1; int lat1;
      int who2; int div2; int lat2;   // who2 = 0: single transaction
   } row_t;

   row_t rows[8];

   initial begin : main
      int lat, who, na0, nb0;

      // full change: 8 edges to ack; fast: 1; second grant after ack: full 9, fast 2
      rows[0] = '{1, 4,  0, 0,  1, 4,  8, 0, 0, 0};
      rows[1] = '{0, 0,  1, 4,  2, 4,  1, 0, 0, 0};
      rows[2] = '{1, 2,  1, 7,  1, 2,  8, 2, 7, 9};
      rows[3] = '{1, 7,  0, 0,  1, 7,  1, 0, 0, 0};
      rows[4] = '{1, 2,  1, 7,  2, 7,  1, 1, 2, 9};
      rows[5] = '{1, 0,  1, 1,  2, 1,  8, 1, 0, 9};
      rows[6] = '{0, 0,  1, 15, 2, 15, 8, 0, 0, 0};
      rows[7] = '{1, 15, 0, 0,  1, 15, 1, 0, 0, 0};

      // ---- reset and boot sequence ----
      repeat (3) step();
      chk("rst_Div_Rst_n", Div_Rst_n, 0);
      chk("rst_CLK_EN", CLK_EN, 0);
      chk("rst_busy", busy, 1);
      chk("rst_div", div, DEF);
      Reset = 1'b1;
      lat = 0;
      for (int t = 1; t <= 20 && lat == 0; t++) begin
         step();
         if (busy === 1'b0) lat = t;
      end
      chk("boot_busy_fall", lat, 1 + S);
      chk("boot_no_ack", na + nb, 0);

      // ---- transaction table ----
      foreach (rows[i]) begin
         wait_idle();
         req_a = rows[i].ra; div_a = W'(rows[i].da);
         req_b = rows[i].rb; div_b = W'(rows[i].db);
         wait_ack(40, lat, who);
         chk($sformatf("row%0d_who1", i), who, rows[i].who1);
         chk($sformatf("row%0d_lat1", i), lat, rows[i].lat1);
         chk($sformatf("row%0d_div1", i), div, rows[i].div1);
         drop(who);
         if (rows[i].who2 != 0) begin
            wait_ack(40, lat, who);
            chk($sformatf("row%0d_who2", i), who, rows[i].who2);
            chk($sformatf("row%0d_lat2", i), lat, rows[i].lat2);
            chk($sformatf("row%0d_div2", i), div, rows[i].div2);
            drop(who);
         end
         req_a = 1'b0; req_b = 1'b0;
      end

      // ---- reset during SETTLE aborts, held request completes afterwards ----
      wait_idle();
      na0 = na;
      req_a = 1'b1; div_a = 4'd10;
      repeat (G + 3) step();            // now in SETTLE
      chk("abort_in_settle", {CLK_EN, Div_Rst_n, busy}, 3'b111);
      Reset = 1'b0;
      step();
      Reset = 1'b1;
      chk("abort_div_default", div, DEF);
      chk("abort_init_rst", Div_Rst_n, 0);
      chk("abort_no_ack", na - na0, 0);
      // boot (1+S) then sampled on the next edge, then a full change
      wait_ack(60, lat, who);
      chk("abort_regrant_lat", lat, 1 + S + FULL_LAT);
      chk("abort_regrant_who", who, 1);
      chk("abort_regrant_div", div, 10);
      drop(1);
      repeat (4) step();
      chk("abort_ack_once", na - na0, 1);

      // ---- one-cycle request; later div_b change ignored ----
      wait_idle();
      nb0 = nb;
      req_b = 1'b1; div_b = 4'd5;
      step();
      req_b = 1'b0; div_b = 4'd3;
      wait_ack(40, lat, who);
      chk("pulse_lat", lat + 1, FULL_LAT);
      chk("pulse_who", who, 2);
      chk("pulse_div", div, 5);
      repeat (6) step();
      chk("pulse_ack_once", nb - nb0, 1);
      chk("pulse_div_hold", div, 5);

      // ---- randomized phase, checked by the timeline model ----
      for (int c = 0; c < 3000; c++) begin
         step();
         if ($urandom_range(0, 599) == 0) Reset = 1'b0;
         else Reset = 1'b1;
         if (req_a && ack_a) req_a = 1'b0;
         else if (!req_a && $urandom_range(0, 7) == 0) begin
            req_a = 1'b1;
            div_a = ($urandom_range(0, 2) == 0) ? div : W'($urandom_range(0, 15));
         end
         if (req_b && ack_b) req_b = 1'b0;
         else if (!req_b && $urandom_range(0, 7) == 0) begin
            req_b = 1'b1;
            div_b = ($urandom_range(0, 2) == 0) ? div : W'($urandom_range(0, 15));
         end
      end
      Reset = 1'b1;
      for (int t = 0; t < 60 && (req_a || req_b); t++) begin
         step();
         if (ack_a) req_a = 1'b0;
         if (ack_b) req_b = 1'b0;
      end
      req_a = 1'b0; req_b = 1'b0;
      wait_idle();
      repeat (3) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
